blur_level_selector: RTL and testbench
======================================

# blur_level_selector

Control stage directly upstream of the blurring filter: converts a stream of dominant-frequency measurements from the audio pitch detector into the 3-bit `freq_flag` kernel select. It averages samples in fixed windows and classifies each average against two thresholds. A candidate kernel level is debounced with hysteresis and committed only on a frame boundary, so the blur kernel never changes mid-frame.

## Interface

Parameters:
- `W`, 16: frequency sample width (Hz, unsigned).
- `AVG_LOG2`, 3: log2 of samples per averaging window (default 8 samples).
- `THRESH_LO`, 500: below this → 5x5 kernel.
- `THRESH_HI`, 2000: at or above this → 1x1 kernel; between → 3x3.
- `HOLD_COUNT`, 4: consecutive agreeing window decisions required before a change arms (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `freq_valid`  in  1  qualifies `freq_in` this cycle.
- `freq_in`  in  W  frequency sample.
- `frame_start`  in  1  one-cycle pulse at start of each video frame.
- `freq_flag`  out  3  committed kernel code: 000 = 1x1, 010 = 3x3, 100 = 5x5.
- `flag_update`  out  1  one-cycle pulse when `freq_flag` takes a new value.

## Operation

- Averager:
  - Accumulator width W+AVG_LOG2 (cannot overflow); sample counter AVG_LOG2 bits.
  - Each `freq_valid` adds `freq_in`. The 2^AVG_LOG2-th valid sample closes the window: avg = (sum + freq_in) >> AVG_LOG2 (truncating).
  - Accumulator and counter clear; the next window starts on the following valid.
- Classifier:
  - avg < THRESH_LO → 100.
  - THRESH_LO ≤ avg < THRESH_HI → 010.
  - avg ≥ THRESH_HI → 000.
  - Produces one registered decision pulse per window.
- FSM on each decision:
  - STABLE: decision = committed → stay. Otherwise candidate ← decision, count ← 1, go to TRACKING, or straight to ARMED if HOLD_COUNT = 1.
  - TRACKING:
    - decision = candidate → count+1; reaching HOLD_COUNT → ARMED.
    - decision = committed → STABLE.
    - Any other value → candidate ← decision, count ← 1.
  - ARMED:
    - decision = committed → STABLE (change cancelled).
    - Any other value ≠ candidate → TRACKING, count 1.
    - frame_start → commit candidate, STABLE.
- Simultaneous frame_start and decision while ARMED: the commit wins and the decision is dropped.
- frame_start in STABLE or TRACKING has no effect.

## Timing

- Reset values:
  - `freq_flag` = 000, `flag_update` = 0.
  - Accumulator, counter and candidate zeroed; state STABLE.
- Reset mid-window discards the partial sum. `freq_valid` is ignored while `reset` is high.
- Decision is registered 1 cycle after the closing sample; the FSM updates on the next edge.
- Commit latency: `freq_flag` shows the new value from the cycle after `frame_start` is sampled. `flag_update` is high for exactly that cycle.
- Back-to-back `freq_valid` every cycle must be sustained with no lost samples.

## Configuration

- `BLUR_HYST_EN` defined: hysteresis as described; HOLD_COUNT is honoured.
- Undefined: counter logic is removed and TRACKING is never entered. Any decision ≠ committed goes directly to ARMED with candidate ← decision; a decision = committed cancels. HOLD_COUNT is ignored.

## Structure

- Shared package `blur_pkg`:
  - kernel code constants `KERNEL_1X1`=3'b000, `KERNEL_3X3`=3'b010, `KERNEL_5X5`=3'b100;
  - FSM state enum (STABLE, TRACKING, ARMED).
  - The blurring filter imports the same kernel constants.
- Sub-module `freq_averager`: accumulator, counter and window-close pulse with average output. Classifier and FSM live in the top.

## Test plan

- Reset mid-window after 5 samples of 3000, then 8 samples of 300 with hysteresis → `freq_flag`=000 and `flag_update`=0 throughout; no arming after one window.
- 32 samples of 300 (4 windows), with `BLUR_HYST_EN`:
  - no frame_start → `freq_flag` stays 000;
  - then frame_start → `freq_flag`=100 next cycle, with a single `flag_update` pulse.
- 3 windows of 1000 then 1 window of 3000, then frame_start → no change (count restarted, never armed).
- From committed 000: arm 010 with 4 windows of 1000, then 1 window of 2500, then frame_start → no change (cancel).
- Boundaries: window avg exactly 500 → 010; exactly 2000 → 000. Samples 499×7 + 507 (avg 500) → 010.
- Without `BLUR_HYST_EN`: one window of 300, then frame_start → `freq_flag`=100. A frame_start coinciding with a decision cycle → commit occurs and that decision is dropped.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared definitions for the blur control path: kernel select codes, the
// kernel-change FSM states and the window-average classifier.
package blur_pkg;

  // Kernel select codes shared with the blurring filter.
  localparam logic [2:0] KERNEL_1X1 = 3'b000;
  localparam logic [2:0] KERNEL_3X3 = 3'b010;
  localparam logic [2:0] KERNEL_5X5 = 3'b100;

  typedef enum logic [1:0] {
    STABLE   = 2'd0,
    TRACKING = 2'd1,
    ARMED    = 2'd2
  } blur_state_t;

  // Low frequencies get the widest kernel, high frequencies no blur.
  function automatic logic [2:0] classify_avg(input int unsigned avg,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (avg < lo)      return KERNEL_5X5;
    else if (avg < hi) return KERNEL_3X3;
    else               return KERNEL_1X1;
  endfunction

endpackage

// File: rtl/freq_averager.sv
// Window averager: sums 2^AVG_LOG2 valid samples and flags the window-closing
// sample together with the truncated average (sum including that sample).
// Outputs are combinational off the accumulator; the caller registers them.
module freq_averager #(
  parameter int W        = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         freq_valid,
  input  logic [W-1:0] freq_in,
  output logic         window_done,
  output logic [W-1:0] avg_out
);

  localparam int SUM_W = W + AVG_LOG2;

  logic [SUM_W-1:0]    sum_reg;
  logic [AVG_LOG2-1:0] cnt_reg;
  logic [SUM_W-1:0]    sum_with_sample;

  assign sum_with_sample = sum_reg + SUM_W'(freq_in);
  assign window_done     = freq_valid && (cnt_reg == '1);
  assign avg_out         = sum_with_sample[SUM_W-1:AVG_LOG2];

  // Accumulate valid samples; the closing sample restarts an empty window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
      cnt_reg <= '0;
    end else if (freq_valid) begin
      if (cnt_reg == '1) begin
        sum_reg <= '0;
        cnt_reg <= '0;
      end else begin
        sum_reg <= sum_with_sample;
        cnt_reg <= cnt_reg + AVG_LOG2'(1);
      end
    end
  end

endmodule

// File: rtl/blur_level_selector.sv
// Kernel level selector: averages pitch-detector frequencies per window,
// classifies each average and commits a kernel change only on frame_start.
// Build option BLUR_HYST_EN: require HOLD_COUNT agreeing window decisions
// before a change arms; without it any differing decision arms directly.
module blur_level_selector
  import blur_pkg::*;
#(
  parameter int W          = 16,
  parameter int AVG_LOG2   = 3,
  parameter int THRESH_LO  = 500,
  parameter int THRESH_HI  = 2000,
  parameter int HOLD_COUNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         freq_valid,
  input  logic [W-1:0] freq_in,
  input  logic         frame_start,
  output logic [2:0]   freq_flag,
  output logic         flag_update
);

  logic         window_done;
  logic [W-1:0] avg_out;

  freq_averager #(.W(W), .AVG_LOG2(AVG_LOG2)) u_avg (
    .clk         (clk),
    .reset       (reset),
    .freq_valid  (freq_valid),
    .freq_in     (freq_in),
    .window_done (window_done),
    .avg_out     (avg_out)
  );

  logic [2:0]  decision_reg;
  logic        decision_valid_reg;
  blur_state_t state_reg, state_next;
  logic [2:0]  candidate_reg, candidate_next;
  logic [2:0]  flag_reg, flag_next;
  logic        update_reg, update_next;

  // One registered decision pulse per closed window.
  always_ff @(posedge clk) begin
    if (reset) begin
      decision_reg       <= KERNEL_1X1;
      decision_valid_reg <= 1'b0;
    end else begin
      decision_valid_reg <= window_done;
      if (window_done)
        decision_reg <= classify_avg(32'(avg_out), THRESH_LO, THRESH_HI);
    end
  end

`ifdef BLUR_HYST_EN
  localparam int CNT_W = (HOLD_COUNT < 2) ? 1 : $clog2(HOLD_COUNT + 1);
  localparam blur_state_t FIRST_STATE = (HOLD_COUNT <= 1) ? ARMED : TRACKING;
  logic [CNT_W-1:0] count_reg, count_next, count_inc;
  assign count_inc = count_reg + CNT_W'(1);

  // Agreement counter register.
  always_ff @(posedge clk) begin
    if (reset) count_reg <= '0;
    else       count_reg <= count_next;
  end
`else
  localparam int unused_hold = HOLD_COUNT;
`endif

  // FSM and committed-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= STABLE;
      candidate_reg <= KERNEL_1X1;
      flag_reg      <= KERNEL_1X1;
      update_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      candidate_reg <= candidate_next;
      flag_reg      <= flag_next;
      update_reg    <= update_next;
    end
  end

  // Next-state logic; a frame_start commit in ARMED overrides any decision.
  always_comb begin
    state_next     = state_reg;
    candidate_next = candidate_reg;
    flag_next      = flag_reg;
    update_next    = 1'b0;
`ifdef BLUR_HYST_EN
    count_next     = count_reg;
`endif
    case (state_reg)
      STABLE: begin
        if (decision_valid_reg && decision_reg != flag_reg) begin
          candidate_next = decision_reg;
`ifdef BLUR_HYST_EN
          count_next     = CNT_W'(1);
          state_next     = FIRST_STATE;
`else
          state_next     = ARMED;
`endif
        end
      end
      TRACKING: begin
`ifdef BLUR_HYST_EN
        if (decision_valid_reg) begin
          if (decision_reg == candidate_reg) begin
            count_next = count_inc;
            if (count_inc == CNT_W'(HOLD_COUNT)) state_next = ARMED;
          end else if (decision_reg == flag_reg) begin
            state_next = STABLE;
          end else begin
            candidate_next = decision_reg;
            count_next     = CNT_W'(1);
          end
        end
`else
        state_next = STABLE;
`endif
      end
      ARMED: begin
        if (frame_start) begin
          flag_next   = candidate_reg;
          update_next = 1'b1;
          state_next  = STABLE;
        end else if (decision_valid_reg) begin
          if (decision_reg == flag_reg) begin
            state_next = STABLE;
          end else if (decision_reg != candidate_reg) begin
            candidate_next = decision_reg;
`ifdef BLUR_HYST_EN
            count_next     = CNT_W'(1);
            state_next     = FIRST_STATE;
`endif
          end
        end
      end
      default: state_next = STABLE;
    endcase
  end

  assign freq_flag   = flag_reg;
  assign flag_update = update_reg;

endmodule

// File: tb/tb_blur_level_selector.sv
// Directed bench for blur_level_selector (default parameters). Works with or
// without BLUR_HYST_EN; expected values are chosen per build.
module tb_blur_level_selector;

  localparam logic [2:0] K1 = 3'b000;
  localparam logic [2:0] K3 = 3'b010;
  localparam logic [2:0] K5 = 3'b100;

`ifdef BLUR_HYST_EN
  localparam int ARM_WINDOWS = 4;
`else
  localparam int ARM_WINDOWS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        freq_valid;
  logic [15:0] freq_in;
  logic        frame_start;
  logic [2:0]  freq_flag;
  logic        flag_update;

  int total = 0;
  int bad   = 0;
  int upd_count = 0;

  blur_level_selector dut (
    .clk         (clk),
    .reset       (reset),
    .freq_valid  (freq_valid),
    .freq_in     (freq_in),
    .frame_start (frame_start),
    .freq_flag   (freq_flag),
    .flag_update (flag_update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (flag_update) upd_count++;

  typedef struct {
    string       name;
    logic [15:0] val;
    logic [15:0] last;
    int          nwin;
    bit          frame;
    logic [2:0]  exp_flag;
    int          exp_upd;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic send_sample(input logic [15:0] v);
    freq_valid = 1'b1;
    freq_in    = v;
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  task automatic send_window(input logic [15:0] v, input logic [15:0] last);
    for (int i = 0; i < 8; i++) send_sample((i == 7) ? last : v);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[$];
  int   u0;

  initial begin
    reset = 1'b1; freq_valid = 1'b0; freq_in = '0; frame_start = 1'b0;

`ifdef BLUR_HYST_EN
    vecs.push_back('{"4x300 no frame",   16'd300,  16'd300,  4, 1'b0, K1, 0});
    vecs.push_back('{"frame commits 5x5",16'd0,    16'd0,    0, 1'b1, K5, 1});
    vecs.push_back('{"3x1000 tracking",  16'd1000, 16'd1000, 3, 1'b0, K5, 0});
    vecs.push_back('{"3000 restarts",    16'd3000, 16'd3000, 1, 1'b1, K5, 0});
    vecs.push_back('{"3x3000 arm+commit",16'd3000, 16'd3000, 3, 1'b1, K1, 1});
    vecs.push_back('{"4x1000 armed",     16'd1000, 16'd1000, 4, 1'b0, K1, 0});
    vecs.push_back('{"2500 cancels",     16'd2500, 16'd2500, 1, 1'b1, K1, 0});
    vecs.push_back('{"avg 500 -> 3x3",   16'd500,  16'd500,  4, 1'b1, K3, 1});
    vecs.push_back('{"avg 2000 -> 1x1",  16'd2000, 16'd2000, 4, 1'b1, K1, 1});
    vecs.push_back('{"499x7+507 -> 3x3", 16'd499,  16'd507,  4, 1'b1, K3, 1});
    vecs.push_back('{"avg 499 -> 5x5",   16'd499,  16'd499,  4, 1'b1, K5, 1});
    vecs.push_back('{"avg 1999 -> 3x3",  16'd1999, 16'd1999, 4, 1'b1, K3, 1});
`else
    vecs.push_back('{"300 arm+commit",   16'd300,  16'd300,  1, 1'b1, K5, 1});
    vecs.push_back('{"1000 armed",       16'd1000, 16'd1000, 1, 1'b0, K5, 0});
    vecs.push_back('{"300 cancels",      16'd300,  16'd300,  1, 1'b1, K5, 0});
    vecs.push_back('{"3000 armed",       16'd3000, 16'd3000, 1, 1'b0, K5, 0});
    vecs.push_back('{"1000 replaces",    16'd1000, 16'd1000, 1, 1'b1, K3, 1});
    vecs.push_back('{"avg 500 stays",    16'd500,  16'd500,  1, 1'b1, K3, 0});
    vecs.push_back('{"avg 2000 -> 1x1",  16'd2000, 16'd2000, 1, 1'b1, K1, 1});
    vecs.push_back('{"499x7+507 -> 3x3", 16'd499,  16'd507,  1, 1'b1, K3, 1});
    vecs.push_back('{"avg 499 -> 5x5",   16'd499,  16'd499,  1, 1'b1, K5, 1});
    vecs.push_back('{"avg 1999 -> 3x3",  16'd1999, 16'd1999, 1, 1'b1, K3, 1});
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset freq_flag", int'(freq_flag), int'(K1));
    check("reset flag_update", int'(flag_update), 0);

    // Reset mid-window: partial sum of 3000s discarded, valid ignored in reset.
    u0 = upd_count;
    for (int i = 0; i < 5; i++) send_sample(16'd3000);
    reset = 1'b1; freq_valid = 1'b1; freq_in = 16'd3000;
    repeat (2) @(negedge clk);
    reset = 1'b0; freq_valid = 1'b0;
    @(negedge clk);
    send_window(16'd300, 16'd300);
    repeat (4) @(negedge clk);
    check("midreset flag", int'(freq_flag), int'(K1));
    check("midreset updates", upd_count - u0, 0);
    pulse_frame();
    repeat (2) @(negedge clk);
`ifdef BLUR_HYST_EN
    check("midreset one window no arm", int'(freq_flag), int'(K1));
    check("midreset frame updates", upd_count - u0, 0);
`else
    check("midreset one window commits", int'(freq_flag), int'(K5));
    check("midreset frame updates", upd_count - u0, 1);
`endif

    // Table-driven vectors from a fresh reset.
    do_reset();
    foreach (vecs[k]) begin
      u0 = upd_count;
      for (int w = 0; w < vecs[k].nwin; w++) send_window(vecs[k].val, vecs[k].last);
      repeat (4) @(negedge clk);
      if (vecs[k].frame) begin
        pulse_frame();
        if (vecs[k].exp_upd != 0) begin
          check({vecs[k].name, " latency flag"}, int'(freq_flag), int'(vecs[k].exp_flag));
          check({vecs[k].name, " latency pulse"}, int'(flag_update), 1);
        end
        repeat (2) @(negedge clk);
      end
      check({vecs[k].name, " flag"}, int'(freq_flag), int'(vecs[k].exp_flag));
      check({vecs[k].name, " updates"}, upd_count - u0, vecs[k].exp_upd);
    end

    // frame_start coinciding with a decision while ARMED: commit, drop decision.
    do_reset();
    for (int w = 0; w < ARM_WINDOWS; w++) send_window(16'd300, 16'd300);
    repeat (4) @(negedge clk);
    u0 = upd_count;
    for (int i = 0; i < 7; i++) send_sample(16'd1000);
    send_sample(16'd1000);
    pulse_frame();
    check("coincide commit flag", int'(freq_flag), int'(K5));
    check("coincide commit pulse", int'(flag_update), 1);
    @(negedge clk);
    check("coincide pulse one cycle", int'(flag_update), 0);
    repeat (3) @(negedge clk);
    pulse_frame();
    repeat (2) @(negedge clk);
    check("coincide decision dropped", int'(freq_flag), int'(K5));
    check("coincide total updates", upd_count - u0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
